// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter family.
//   DIR_UP / DIR_DOWN   : values of the direction input.
//   MODE_WRAP / MODE_SAT: values of the boundary-mode input.
//   next_count()        : one step of an up/down counter bounded by 0..max_count.
//                         Works on a 32-bit container so counters of any width
//                         up to 32 bits can reuse it.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CNT_W_MAX = 32;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] count;
    logic                 tc;
  } step_res_t;

  // One step; the boundary test is done before any add/subtract, so the
  // result never leaves 0..max_count and never overflows the caller's width.
  function automatic step_res_t next_count(
    input logic [CNT_W_MAX-1:0] count,
    input logic [CNT_W_MAX-1:0] max_count,
    input logic                 up,
    input logic                 sat
  );
    step_res_t res;
    res.count = count;
    res.tc    = 1'b0;
    if (up == DIR_UP) begin
      if (count < max_count) begin
        res.count = count + 32'd1;
        res.tc    = 1'b0;
      end else begin
        res.count = (sat == MODE_SAT) ? max_count : 32'd0;
        res.tc    = 1'b1;
      end
    end else begin
      if (count != 32'd0) begin
        res.count = count - 32'd1;
        res.tc    = 1'b0;
      end else begin
        res.count = (sat == MODE_SAT) ? 32'd0 : max_count;
        res.tc    = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/count_dp.sv
// count_dp: count and terminal-count registers plus next-count selection.
// Priority at each edge: reset > load > step > hold.
//   clk_21, rst_21   in  : clock and synchronous active-high reset.
//   tick_21          in  : step strobe from the prescaler.
//   up_21, sat_21    in  : direction and boundary mode, used on step edges.
//   load_21          in  : synchronous load, value clamped to MAX_COUNT.
//   load_val_21      in  : load value.
//   count_21         out : registered count.
//   tc_21            out : registered terminal-count pulse.
module count_dp
  import counter_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int MAX_COUNT = 2**SIZE - 1
) (
  input  logic            clk_21,
  input  logic            rst_21,
  input  logic            tick_21,
  input  logic            up_21,
  input  logic            sat_21,
  input  logic            load_21,
  input  logic [SIZE-1:0] load_val_21,
  output logic [SIZE-1:0] count_21,
  output logic            tc_21
);

  localparam logic [SIZE-1:0] MAX_C = SIZE'(MAX_COUNT);

  logic [SIZE-1:0] count_r;
  logic            tc_r;
  logic [SIZE-1:0] count_nxt_s;
  logic            tc_nxt_s;
  step_res_t       step_s;

  // Step result from the shared function; the upper container bits are
  // always zero because results stay within 0..MAX_COUNT.
  assign step_s = next_count(32'(count_r), 32'(MAX_C), up_21, sat_21);

  generate
    if (SIZE < CNT_W_MAX) begin : g_hi
      logic unused_hi_s;
      assign unused_hi_s = ^step_s.count[CNT_W_MAX-1:SIZE];
    end
  endgenerate

  // Next count / terminal count selection.
  always_comb begin
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    if (load_21) begin
      count_nxt_s = (load_val_21 > MAX_C) ? MAX_C : load_val_21;
      tc_nxt_s    = 1'b0;
    end else if (tick_21) begin
      count_nxt_s = step_s.count[SIZE-1:0];
      tc_nxt_s    = step_s.tc;
    end else begin
      count_nxt_s = count_r;
      tc_nxt_s    = 1'b0;
    end
  end

  // Count and terminal-count registers.
  always_ff @(posedge clk_21) begin
    if (rst_21) begin
      count_r <= {SIZE{1'b0}};
      tc_r    <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
    end
  end

  assign count_21 = count_r;
  assign tc_21    = tc_r;

endmodule

// File: rtl/prescale_ctrl.sv
// prescale_ctrl: turns a held enable into a one-cycle step strobe every
// PRESCALE consecutive enabled cycles. Dropping the enable discards any
// partial run.
//   clk_21  in  : clock, rising edge.
//   rst_21  in  : synchronous reset, active high.
//   enb_21  in  : count enable.
//   tick_21 out : registered step strobe.
module prescale_ctrl
  import counter_pkg::*;
#(
  parameter int PRESCALE = 3
) (
  input  logic clk_21,
  input  logic rst_21,
  input  logic enb_21,
  output logic tick_21
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_r;
  logic [PRE_W-1:0] pre_cnt_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;

  // Next prescaler count and strobe.
  always_comb begin
    pre_cnt_nxt_s = {PRE_W{1'b0}};
    tick_nxt_s    = 1'b0;
    if (!enb_21) begin
      pre_cnt_nxt_s = {PRE_W{1'b0}};
      tick_nxt_s    = 1'b0;
    end else if (pre_cnt_r == PRE_LAST) begin
      pre_cnt_nxt_s = {PRE_W{1'b0}};
      tick_nxt_s    = 1'b1;
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
      tick_nxt_s    = 1'b0;
    end
  end

  // Prescaler state and strobe registers.
  always_ff @(posedge clk_21) begin
    if (rst_21) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      tick_r    <= 1'b0;
    end else begin
      pre_cnt_r <= pre_cnt_nxt_s;
      tick_r    <= tick_nxt_s;
    end
  end

  assign tick_21 = tick_r;

endmodule

// File: rtl/prog_counter_rtl.sv
// prog_counter_rtl: prescaled up/down counter, modulo MAX_COUNT+1, wrap or
// saturate, with synchronous load and terminal-count pulse.
//   clk_21      in  : clock, rising edge.
//   rst_21      in  : synchronous reset, active high.
//   enb_21      in  : count enable.
//   up_21       in  : 1 = up, 0 = down.
//   sat_21      in  : 1 = saturate, 0 = wrap.
//   load_21     in  : synchronous load strobe.
//   load_val_21 in  : load value.
//   count_21    out : registered count.
//   tick_21     out : registered step strobe.
//   tc_21       out : registered terminal-count pulse.
module prog_counter_rtl
  import counter_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int PRESCALE  = 3,
  parameter int MAX_COUNT = 2**SIZE - 1
) (
  input  logic            clk_21,
  input  logic            rst_21,
  input  logic            enb_21,
  input  logic            up_21,
  input  logic            sat_21,
  input  logic            load_21,
  input  logic [SIZE-1:0] load_val_21,
  output logic [SIZE-1:0] count_21,
  output logic            tick_21,
  output logic            tc_21
);

  logic tick_s;

  prescale_ctrl #(
    .PRESCALE (PRESCALE)
  ) u_prescale_ctrl (
    .clk_21  (clk_21),
    .rst_21  (rst_21),
    .enb_21  (enb_21),
    .tick_21 (tick_s)
  );

  count_dp #(
    .SIZE      (SIZE),
    .MAX_COUNT (MAX_COUNT)
  ) u_count_dp (
    .clk_21      (clk_21),
    .rst_21      (rst_21),
    .tick_21     (tick_s),
    .up_21       (up_21),
    .sat_21      (sat_21),
    .load_21     (load_21),
    .load_val_21 (load_val_21),
    .count_21    (count_21),
    .tc_21       (tc_21)
  );

  assign tick_21 = tick_s;

endmodule

// File: tb/tb_prog_counter_rtl.sv
// tb_prog_counter_rtl: two counter instances driven by the same inputs
//   dut_a: SIZE=4, PRESCALE=1, MAX_COUNT=15
//   dut_b: SIZE=4, PRESCALE=3, MAX_COUNT=9
// Every cycle the outputs of both are compared with a reference model that
// tracks the length of the current enable run and applies the counting rules
// with plain integer arithmetic.
module tb_prog_counter_rtl;

  logic       clk_21 = 1'b0;
  logic       rst_21;
  logic       enb_21;
  logic       up_21;
  logic       sat_21;
  logic       load_21;
  logic [3:0] load_val_21;

  logic [3:0] count_a, count_b;
  logic       tick_a, tick_b, tc_a, tc_b;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int m_pre [2] = '{1, 3};
  int m_max [2] = '{15, 9};
  int m_run [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_tick[2] = '{0, 0};
  int m_tc  [2] = '{0, 0};

  always #5 clk_21 = ~clk_21;

  prog_counter_rtl #(.SIZE(4), .PRESCALE(1), .MAX_COUNT(15)) dut_a (
    .clk_21(clk_21), .rst_21(rst_21), .enb_21(enb_21), .up_21(up_21),
    .sat_21(sat_21), .load_21(load_21), .load_val_21(load_val_21),
    .count_21(count_a), .tick_21(tick_a), .tc_21(tc_a)
  );

  prog_counter_rtl #(.SIZE(4), .PRESCALE(3), .MAX_COUNT(9)) dut_b (
    .clk_21(clk_21), .rst_21(rst_21), .enb_21(enb_21), .up_21(up_21),
    .sat_21(sat_21), .load_21(load_21), .load_val_21(load_val_21),
    .count_21(count_b), .tick_21(tick_b), .tc_21(tc_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Apply the counting rules at one rising edge, using the inputs in force.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int tick_old;
      tick_old = m_tick[i];
      if (rst_21) begin
        m_run[i] = 0; m_tick[i] = 0; m_cnt[i] = 0; m_tc[i] = 0;
      end else begin
        if (enb_21) begin
          m_run[i]  = m_run[i] + 1;
          m_tick[i] = (m_run[i] % m_pre[i] == 0) ? 1 : 0;
        end else begin
          m_run[i]  = 0;
          m_tick[i] = 0;
        end
        if (load_21) begin
          m_cnt[i] = (int'(load_val_21) > m_max[i]) ? m_max[i] : int'(load_val_21);
          m_tc[i]  = 0;
        end else if (tick_old != 0) begin
          if (up_21) begin
            if (m_cnt[i] == m_max[i]) begin
              m_cnt[i] = sat_21 ? m_max[i] : 0;
              m_tc[i]  = 1;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
              m_tc[i]  = 0;
            end
          end else begin
            if (m_cnt[i] == 0) begin
              m_cnt[i] = sat_21 ? 0 : m_max[i];
              m_tc[i]  = 1;
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
              m_tc[i]  = 0;
            end
          end
        end else begin
          m_tc[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_21);
    model_edge();
    #1;
    check_val("count_a", 32'(count_a), m_cnt[0]);
    check_val("tick_a",  32'(tick_a),  m_tick[0]);
    check_val("tc_a",    32'(tc_a),    m_tc[0]);
    check_val("count_b", 32'(count_b), m_cnt[1]);
    check_val("tick_b",  32'(tick_b),  m_tick[1]);
    check_val("tc_b",    32'(tc_b),    m_tc[1]);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic s,
                       input logic l, input logic [3:0] lv, input int n);
    rst_21 = r; enb_21 = e; up_21 = u; sat_21 = s; load_21 = l; load_val_21 = lv;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    rst_21 = 1'b1; enb_21 = 1'b0; up_21 = 1'b1; sat_21 = 1'b0;
    load_21 = 1'b0; load_val_21 = 4'd0;

    // reset state
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2);
    check_val("reset_count_a", 32'(count_a), 0);
    check_val("reset_count_b", 32'(count_b), 0);

    // up, wrap, enable held: full sweep with wrap on dut_a
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 20);

    // enable for 3 cycles then low; then only 2 cycles
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3);
    check_val("pre3_one_step_b", 32'(count_b), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3);
    check_val("pre3_short_run_b", 32'(count_b), 1);

    // down, saturate from 2
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 15);
    check_val("down_sat_floor_b", 32'(count_b), 0);

    // load above MAX_COUNT, then wrap up and down through the boundary
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd12, 1);
    check_val("load_clamp_b", 32'(count_b), 9);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 6);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 9);

    // load coincident with tick: count 5, load 3 on the tick edge
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1);
    check_val("load_beats_tick_b", 32'(count_b), 3);
    check_val("load_tc_b", 32'(tc_b), 0);

    // reset together with load and tick
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1);
    check_val("rst_wins_count_b", 32'(count_b), 0);
    check_val("rst_wins_tick_b", 32'(tick_b), 0);

    // direction flip at 7, then saturate up at the top
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4);
    check_val("sat_up_top_a", 32'(count_a), 15);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, e, l, u, s;
      r = ($urandom_range(99) == 0);
      e = ($urandom_range(9) < 8);
      l = ($urandom_range(19) == 0);
      u = ($urandom_range(15) == 0) ? ~up_21  : up_21;
      s = ($urandom_range(31) == 0) ? ~sat_21 : sat_21;
      drive(r, e, u, s, l, 4'($urandom_range(15)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
